// File: rtl/display_pkg.sv
// Shared types and helpers for the score/timer display path.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    localparam int BCD_DIGIT_W = 4;

    function automatic longint unsigned max_decimal(input int num_digits);
        longint unsigned result;
        result = 1;
        for (int i = 0; i < num_digits; i++) begin
            result = result * 10;
        end
        return result - 1;
    endfunction

endpackage

// File: rtl/bcd_converter_dabble_digit.sv
// One double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module dabble_digit
    import display_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= BCD_DIGIT_W'(5)) ? digit_in + BCD_DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD encoder (double-dabble, one shift per clock) with a
// start/ready/done handshake and saturation at the largest displayable value.
module bcd_converter
    import display_pkg::*;
#(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [BIN_WIDTH-1:0]              value,
    output logic                              ready,
    output logic                              done,
    output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] digits,
    output logic                              overflow
);

    localparam int SCR_W = NUM_DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam longint unsigned MAX_VALUE = max_decimal(NUM_DIGITS);
    // When the input width cannot reach MAX_VALUE, clamping never triggers.
    localparam bit CAN_OVF = MAX_VALUE < (64'd1 << BIN_WIDTH);
    localparam logic [BIN_WIDTH-1:0] MAX_BIN = CAN_OVF ? BIN_WIDTH'(MAX_VALUE) : '1;

    conv_state_t          state;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [SCR_W-1:0]     scratch_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_pending;

    logic [SCR_W-1:0]     adjusted;
    logic [SCR_W-1:0]     scratch_next;
    logic                 value_ovf;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dabble
        dabble_digit u_dabble (
            .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign scratch_next = {adjusted[SCR_W-2:0], bin_q[BIN_WIDTH-1]};
    assign value_ovf    = CAN_OVF && (value > MAX_BIN);

    // Results are registered on the final shift edge so they are already
    // valid during the single DONE cycle in which done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            ovf_pending <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
            digits      <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_q       <= value_ovf ? MAX_BIN : value;
                        scratch_q   <= '0;
                        cnt_q       <= CNT_W'(BIN_WIDTH);
                        ovf_pending <= value_ovf;
                        ready       <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_next;
                    bin_q     <= bin_q << 1;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        digits   <= scratch_next;
                        overflow <= ovf_pending;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter at default parameters.
module tb_bcd_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] value;
    logic        ready;
    logic        done;
    logic [15:0] digits;
    logic        overflow;

    int assertCount = 0;
    int failCount   = 0;

    bcd_converter #(
        .BIN_WIDTH  (14),
        .NUM_DIGITS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .ready    (ready),
        .done     (done),
        .digits   (digits),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Leaves the bench at the first sample point after start was accepted.
    task automatic applyStimulus(input logic [13:0] v);
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runConversion(input string tag, input logic [13:0] v,
                                 input logic [15:0] expDigits, input logic expOvf);
        int cyc;
        applyStimulus(v);
        checkOutput({tag, "_ready_low"}, 32'(ready), 32'd0);
        waitDone(cyc);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'd15);
        checkOutput({tag, "_digits"}, 32'(digits), 32'(expDigits));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(expOvf));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    task automatic countDone(input int window, output int pulses, output logic [15:0] lastDigits);
        pulses     = 0;
        lastDigits = digits;
        for (int i = 0; i < window; i++) begin
            if (done) begin
                pulses++;
                lastDigits = digits;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          cyc;
        int          pulses;
        logic [15:0] seen;

        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_digits", 32'(digits), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        runConversion("v1234", 14'd1234, 16'h1234, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        value = 14'd0;
        @(negedge clk);
        waitDone(cyc);
        checkOutput("b2b0_latency", 32'(cyc), 32'd15);
        checkOutput("b2b0_digits", 32'(digits), 32'h0000);
        checkOutput("b2b0_overflow", 32'(overflow), 32'd0);
        value = 14'd9999;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        start = 1'b0;
        checkOutput("b2b_spacing", 32'(cyc), 32'd16);
        checkOutput("b2b9999_digits", 32'(digits), 32'h9999);
        checkOutput("b2b9999_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        checkOutput("b2b_ready_back", 32'(ready), 32'd1);

        runConversion("v10000", 14'd10000, 16'h9999, 1'b1);
        runConversion("v16383", 14'd16383, 16'h9999, 1'b1);
        runConversion("v42", 14'd42, 16'h0042, 1'b0);

        // Start while busy is dropped; value changes do not disturb the result
        applyStimulus(14'd777);
        repeat (3) @(negedge clk);
        start = 1'b1;
        value = 14'd500;
        @(negedge clk);
        start = 1'b0;
        value = 14'd123;
        countDone(25, pulses, seen);
        checkOutput("busy_pulses", 32'(pulses), 32'd1);
        checkOutput("busy_digits", 32'(seen), 32'h0777);
        checkOutput("busy_digits_hold", 32'(digits), 32'h0777);

        // Reset in the middle of a conversion
        runConversion("v99", 14'd99, 16'h0099, 1'b0);
        applyStimulus(14'd4321);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_digits", 32'(digits), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_ready", 32'(ready), 32'd1);
        countDone(25, pulses, seen);
        checkOutput("midrst_no_done", 32'(pulses), 32'd0);

        // Reset and start together
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        value = 14'd1234;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rststart_ready", 32'(ready), 32'd1);
        countDone(20, pulses, seen);
        checkOutput("rststart_no_done", 32'(pulses), 32'd0);
        checkOutput("rststart_ready_idle", 32'(ready), 32'd1);
        checkOutput("rststart_digits", 32'(digits), 32'd0);

        runConversion("v58", 14'd58, 16'h0058, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
